ps2_letter_decoder: RTL
=======================

// Module: ps2_letter_decoder
// PURPOSE
//   Upstream stage of the hangman datapath. Receives PS/2 set-2 scan codes from the keyboard.
//   Turns letter key presses into the 5-bit char/guess code the datapath consumes: a=1 .. z=26, 0 = none.
//   Also emits Enter and Backspace strobes for the control FSM.
//   Break (key release) and extended sequences are filtered here, so downstream sees one pulse per press.
// PARAMETERS
//   SYNC_STAGES  2      flip-flop stages on ps2_clk/ps2_dat before use (min 2)
//   TIMEOUT_CYC  50000  clk cycles with no ps2_clk falling edge mid-frame before abort (1 ms @ 50 MHz)
// PORTS
//   clk          in   1  system clock; all logic on posedge
//   resetn       in   1  synchronous reset, active-HIGH despite the name
//   ps2_clk      in   1  raw PS/2 clock from the pin, asynchronous
//   ps2_dat      in   1  raw PS/2 data from the pin, asynchronous
//   char         out  5  last decoded letter, 1..26; holds its value between strobes
//   char_valid   out  1  1-cycle strobe: char was updated
//   enter_pulse  out  1  1-cycle strobe on an Enter make code (0x5A or E0 5A)
//   bksp_pulse   out  1  1-cycle strobe on a Backspace make code (0x66)
//   frame_err    out  1  1-cycle strobe: bad parity, bad stop bit, or timeout
// BEHAVIOUR
//   Reset: all outputs 0, FSM in IDLE, bit count 0, break/ext flags 0, timeout counter 0.
//   Input sync: ps2_clk and ps2_dat each pass through SYNC_STAGES flops.
//     fall = prev_synced_clk & ~synced_clk. Data is sampled only in a fall cycle.
//   Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
//     IDLE: on fall, if dat==0 go to DATA, else stay (glitch ignored, no error).
//     DATA: 8 falls, shifted in LSB first.
//     PARITY: on fall, capture the bit.
//     STOP: on fall, check stop==1 and odd parity over data+parity. Pass -> byte_rdy; fail -> frame_err. Go to IDLE.
//   Timeout: counter clears on every fall and in IDLE; otherwise it counts.
//     When it reaches TIMEOUT_CYC: frame_err, go to IDLE, discard the partial byte. Break/ext flags are kept.
//   Byte layer, evaluated in the byte_rdy cycle:
//     0xE0: set ext.
//     0xF0: set brk.
//     Any other byte with brk=1: release; no output; clear brk and ext.
//     Make with ext=1: 0x5A -> enter_pulse; all others ignored. Clear ext.
//     Make with ext=0: letter LUT hit -> char/char_valid; 0x5A -> enter_pulse; 0x66 -> bksp_pulse; others ignored.
//   Latency: each strobe asserts exactly 1 clk after the cycle in which the stop-bit fall is detected.
//   At most one strobe is asserted in any cycle. The strobes are mutually exclusive.
//   A fall arriving in the same cycle as byte_rdy is valid: the FSM accepts it as a start bit. No stall.
//   resetn mid-frame: the partial byte is dropped. Flags and outputs go to their reset values on the next edge.
//   Bytes 0x00 and 0xFF (keyboard error/overrun) are discarded silently. Flags are unchanged.
// CONFIGURATION
//   PS2_REPEAT_FILTER_EN defined:
//     Register last_make[7:0], reset value 0.
//     A make equal to last_make, with no matching release in between, is suppressed (typematic repeat).
//     A release of last_make clears it. A different make replaces it.
//     Applies to letters, Enter and Backspace.
//   Undefined: every make code, including keyboard auto-repeats, produces its strobe.
// STRUCTURE
//   Shared package ps2_pkg:
//     set-2 constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_ENTER=8'h5A, SC_BKSP=8'h66
//     function letter_code(byte) -> 5'd1..26 or 0, covering 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A
//     frame FSM state encoding
//   Sub-module ps2_frame_rx: sync, fall detect, frame FSM and timeout.
//     Outputs byte[7:0], byte_rdy, frame_err.
//   Top level: byte layer, flags, optional repeat filter and output registers.
// TESTING
//   1. Frame 0x1C, then F0 1C, at ~12 kHz -> one char_valid with char=1. No strobe for the release.
//   2. Frame 0x1A with the parity bit flipped -> frame_err for 1 cycle. No char_valid. char keeps its previous value.
//   3. E0 5A, then plain 5A -> two enter_pulse, each 1 clk after its stop-bit fall.
//      E0 75 (arrow key) -> no strobe.
//   4. Stop after 4 data bits, wait TIMEOUT_CYC+2 clk -> frame_err.
//      Then a full 0x66 frame -> bksp_pulse.
//   5. resetn asserted for 1 cycle during data bit 5 -> all outputs 0.
//      Next full 0x1D frame -> char=23, char_valid.
//   6. With PS2_REPEAT_FILTER_EN: 1C 1C 1C F0 1C 1C -> exactly two char_valid (char=1).
//      Without the macro -> four char_valid.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 scan-code constants, the letter lookup and the frame FSM state encoding.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_NULL  = 8'h00;
    localparam logic [7:0] SC_OVR   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Set-2 make code -> a=1 .. z=26, 0 when the code is not a letter
    function automatic logic [4:0] letter_code(input logic [7:0] sc);
        case (sc)
            8'h1C: return 5'd1;
            8'h32: return 5'd2;
            8'h21: return 5'd3;
            8'h23: return 5'd4;
            8'h24: return 5'd5;
            8'h2B: return 5'd6;
            8'h34: return 5'd7;
            8'h33: return 5'd8;
            8'h43: return 5'd9;
            8'h3B: return 5'd10;
            8'h42: return 5'd11;
            8'h4B: return 5'd12;
            8'h3A: return 5'd13;
            8'h31: return 5'd14;
            8'h44: return 5'd15;
            8'h4D: return 5'd16;
            8'h15: return 5'd17;
            8'h2D: return 5'd18;
            8'h1B: return 5'd19;
            8'h2C: return 5'd20;
            8'h3C: return 5'd21;
            8'h2A: return 5'd22;
            8'h1D: return 5'd23;
            8'h22: return 5'd24;
            8'h35: return 5'd25;
            8'h1A: return 5'd26;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame FSM and mid-frame timeout.
// o_byte_rdy / o_frame_err are single-cycle strobes valid in the cycle the terminating fall is seen.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_byte,
    output logic       o_byte_rdy,
    output logic       o_frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    rx_state_t              r_state;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic [TO_W-1:0]        r_to_cnt;

    logic w_clk;
    logic w_dat;
    logic w_fall;
    logic w_timeout;
    logic w_stop_fall;
    logic w_frame_ok;

    assign w_clk       = r_clk_sync[SYNC_STAGES-1];
    assign w_dat       = r_dat_sync[SYNC_STAGES-1];
    assign w_fall      = r_clk_prev & ~w_clk;
    assign w_timeout   = (r_state != ST_IDLE) && (r_to_cnt == TO_MAX);
    assign w_stop_fall = (r_state == ST_STOP) && w_fall && !w_timeout;
    // stop bit high and odd parity across the 8 data bits plus parity bit
    assign w_frame_ok  = w_dat && (^{r_shift, r_par});

    assign o_byte      = r_shift;
    assign o_byte_rdy  = w_stop_fall && w_frame_ok;
    assign o_frame_err = w_timeout || (w_stop_fall && !w_frame_ok);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
            r_clk_prev <= w_clk;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (r_state == ST_IDLE || w_fall)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TO_W'(1);

            if (w_timeout) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= 3'd0;
            end else if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_dat) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        r_shift   <= {w_dat, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        r_par   <= w_dat;
                        r_state <= ST_STOP;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_letter_decoder.sv
// Scan-code byte layer: break/extended filtering, letter LUT and registered one-cycle strobes.
// Optional typematic-repeat suppression is compiled in with PS2_REPEAT_FILTER_EN.
module ps2_letter_decoder
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [4:0] char,
    output logic       char_valid,
    output logic       enter_pulse,
    output logic       bksp_pulse,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_rdy;
    logic       w_rx_err;
    logic       w_discard;
    logic       w_is_make;
    logic       w_is_release;
    logic       w_rep;
    logic [4:0] w_letter;
    logic       r_brk;
    logic       r_ext;

    ps2_frame_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .i_clk      (clk),
        .i_rst      (resetn),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_dat  (ps2_dat),
        .o_byte     (w_byte),
        .o_byte_rdy (w_rdy),
        .o_frame_err(w_rx_err)
    );

    // 00/FF are keyboard error/overrun reports and leave the flags untouched
    assign w_discard    = (w_byte == SC_NULL) || (w_byte == SC_OVR);
    assign w_is_make    = w_rdy && !w_discard && (w_byte != SC_EXT) && (w_byte != SC_BRK) && !r_brk;
    assign w_is_release = w_rdy && !w_discard && (w_byte != SC_EXT) && (w_byte != SC_BRK) && r_brk;
    assign w_letter     = letter_code(w_byte);

`ifdef PS2_REPEAT_FILTER_EN
    logic [7:0] r_last_make;

    assign w_rep = (w_byte == r_last_make);

    always_ff @(posedge clk) begin
        if (resetn)
            r_last_make <= 8'd0;
        else if (w_is_make)
            r_last_make <= w_byte;
        else if (w_is_release && w_rep)
            r_last_make <= 8'd0;
    end
`else
    assign w_rep = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (resetn) begin
            char        <= 5'd0;
            char_valid  <= 1'b0;
            enter_pulse <= 1'b0;
            bksp_pulse  <= 1'b0;
            frame_err   <= 1'b0;
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
        end else begin
            char_valid  <= 1'b0;
            enter_pulse <= 1'b0;
            bksp_pulse  <= 1'b0;
            frame_err   <= w_rx_err;

            if (w_rdy && !w_discard) begin
                if (w_byte == SC_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == SC_BRK) begin
                    r_brk <= 1'b1;
                end else if (r_brk) begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end else begin
                    r_ext <= 1'b0;
                    if (!w_rep) begin
                        if (r_ext) begin
                            enter_pulse <= (w_byte == SC_ENTER);
                        end else if (w_letter != 5'd0) begin
                            char       <= w_letter;
                            char_valid <= 1'b1;
                        end else if (w_byte == SC_ENTER) begin
                            enter_pulse <= 1'b1;
                        end else if (w_byte == SC_BKSP) begin
                            bksp_pulse <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    logic w_unused;
    assign w_unused = w_is_release;

endmodule
